// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: in-order WB stage vs buffered secondary.
// Optional same-cycle secondary bypass when idle: RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     p_valid,
  input  logic [ADDR_W-1:0]        p_reg,
  input  logic [DATA_W-1:0]        p_data,
  output logic                     p_stall,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ADDR_W-1:0]        s_reg,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     W_Enable,
  output logic [ADDR_W-1:0]        W_Reg,
  output logic [DATA_W-1:0]        W_data,
  input  logic [ADDR_W-1:0]        q_reg1,
  input  logic [ADDR_W-1:0]        q_reg2,
  output logic                     q_pend1,
  output logic                     q_pend2,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [ADDR_W-1:0] reg_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     starve_q;

  logic              w_en_q;
  logic [ADDR_W-1:0] w_reg_q;
  logic [DATA_W-1:0] w_dat_q;

  logic fifo_ne, force_s;
  logic grant_p, grant_s, grant_b;
  logic push, pop;
  logic pend1, pend2;
  logic [PW-1:0] off;

  assign fifo_ne = cnt_q != '0;
  assign force_s = fifo_ne &&
                   (starve_q == SW'(STARVE_MAX));
  assign grant_p = p_valid && !force_s;
  assign grant_s = fifo_ne && !grant_p;
  assign s_ready = cnt_q < CW'(DEPTH);

`ifdef RF_WB_BYPASS_EN
  // idle and empty: a new secondary write skips the FIFO
  assign grant_b = !fifo_ne && !p_valid && s_valid;
`else
  assign grant_b = 1'b0;
`endif

  assign push    = s_valid && s_ready && !grant_b;
  assign pop     = grant_s;
  assign p_stall = p_valid && !grant_p;

  assign W_Enable = w_en_q;
  assign W_Reg    = w_reg_q;
  assign W_data   = w_dat_q;
  assign fifo_cnt = cnt_q;

  // FIFO storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_q] <= s_reg;
      dat_q[wr_q] <= s_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // count primary wins while secondary waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else if (!fifo_ne || grant_s) begin
      starve_q <= '0;
    end else if (grant_p &&
                 starve_q != SW'(STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // registered RF write port; $zero writes are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en_q  <= 1'b0;
      w_reg_q <= '0;
      w_dat_q <= '0;
    end else begin
      unique case (1'b1)
        grant_p: begin
          w_en_q  <= p_reg != '0;
          w_reg_q <= p_reg;
          w_dat_q <= p_data;
        end
        grant_s: begin
          w_en_q  <= reg_q[rd_q] != '0;
          w_reg_q <= reg_q[rd_q];
          w_dat_q <= dat_q[rd_q];
        end
        grant_b: begin
          w_en_q  <= s_reg != '0;
          w_reg_q <= s_reg;
          w_dat_q <= s_data;
        end
        default: w_en_q <= 1'b0;
      endcase
    end
  end

  // match lookups against occupied FIFO slots
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if ({1'b0, off} < cnt_q) begin
        if (reg_q[i] == q_reg1) pend1 = 1'b1;
        if (reg_q[i] == q_reg2) pend2 = 1'b1;
      end
    end
  end

  assign q_pend1 = pend1 && (q_reg1 != '0);
  assign q_pend2 = pend2 && (q_reg2 != '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized bench for rf_wb_arbiter against a queue-based model.
// Honours RF_WB_BYPASS_EN the same way the design does.
module tb_rf_wb_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          p_valid, p_stall;
  logic [AW-1:0] p_reg;
  logic [DW-1:0] p_data;
  logic          s_valid, s_ready;
  logic [AW-1:0] s_reg;
  logic [DW-1:0] s_data;
  logic          W_Enable;
  logic [AW-1:0] W_Reg;
  logic [DW-1:0] W_data;
  logic [AW-1:0] q_reg1, q_reg2;
  logic          q_pend1, q_pend2;
  logic [CW-1:0] fifo_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .DATA_W(DW), .ADDR_W(AW),
    .DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .p_valid(p_valid), .p_reg(p_reg),
    .p_data(p_data), .p_stall(p_stall),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_reg(s_reg), .s_data(s_data),
    .W_Enable(W_Enable), .W_Reg(W_Reg),
    .W_data(W_data),
    .q_reg1(q_reg1), .q_reg2(q_reg2),
    .q_pend1(q_pend1), .q_pend2(q_pend2),
    .fifo_cnt(fifo_cnt)
  );

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  int            starve;
  logic          ew;
  logic [AW-1:0] er;
  logic [DW-1:0] ed;
  bit            last_stall;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic bit pend(logic [AW-1:0] q);
    if (q == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].r == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input bit pv,
                       input int pr, input int pd,
                       input bit sv,
                       input int sr, input int sd,
                       input int q1, input int q2);
    @(negedge clk);
    p_valid = pv;
    p_reg   = AW'(pr);
    p_data  = DW'(pd);
    s_valid = sv;
    s_reg   = AW'(sr);
    s_data  = DW'(sd);
    q_reg1  = AW'(q1);
    q_reg2  = AW'(q2);
  endtask

  // one cycle: check combinational outputs, then the edge
  task automatic step();
    bit   ne, fs, gp, gs, gb, sr;
    ent_t e;
    ne = mq.size() != 0;
    fs = ne && starve == SMAX;
    gp = p_valid && !fs;
    gs = ne && !gp;
    sr = mq.size() < DEPTH;
    gb = BYP && !ne && !p_valid && s_valid;
    #1;
    chk("p_stall", 32'(p_stall), 32'(p_valid && !gp));
    chk("s_ready", 32'(s_ready), 32'(sr));
    chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
    chk("q_pend1", 32'(q_pend1), 32'(pend(q_reg1)));
    chk("q_pend2", 32'(q_pend2), 32'(pend(q_reg2)));
    last_stall = p_valid && !gp;
    @(posedge clk);
    if (gp) begin
      ew = p_reg != 0; er = p_reg; ed = p_data;
    end else if (gs) begin
      e  = mq.pop_front();
      ew = e.r != 0; er = e.r; ed = e.d;
    end else if (gb) begin
      ew = s_reg != 0; er = s_reg; ed = s_data;
    end else begin
      ew = 1'b0;
    end
    if (s_valid && sr && !gb) begin
      e.r = s_reg; e.d = s_data;
      mq.push_back(e);
    end
    if (!ne || gs) starve = 0;
    else if (gp && starve < SMAX) starve++;
    #1;
    chk("W_Enable", 32'(W_Enable), 32'(ew));
    chk("W_Reg", 32'(W_Reg), 32'(er));
    chk("W_data", W_data, ed);
  endtask

  task automatic model_clear();
    mq.delete();
    starve = 0;
    ew = 1'b0; er = '0; ed = '0;
    last_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p_valid = 0; p_reg = '0; p_data = '0;
    s_valid = 0; s_reg = '0; s_data = '0;
    q_reg1 = '0; q_reg2 = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wen", 32'(W_Enable), 32'd0);
    chk("rst_wreg", 32'(W_Reg), 32'd0);
    chk("rst_wdata", W_data, 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd1);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_stall", 32'(p_stall), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic rand_phase(input int n,
                            input int ppct,
                            input int spct);
    repeat (n) begin
      @(negedge clk);
      if (!last_stall) begin
        p_valid = $urandom_range(0, 99) < ppct;
        p_reg   = AW'($urandom_range(0, 7));
        p_data  = $urandom;
      end
      s_valid = $urandom_range(0, 99) < spct;
      s_reg   = AW'($urandom_range(0, 7));
      s_data  = $urandom;
      q_reg1  = AW'($urandom_range(0, 7));
      q_reg2  = AW'($urandom_range(0, 7));
      step();
    end
  endtask

  int stall_at;
  int lat;

  initial begin
    do_reset();

    // primary single write
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step();
    chk("t2_wen", 32'(W_Enable), 32'd1);
    chk("t2_wreg", 32'(W_Reg), 32'd5);
    chk("t2_wdata", W_data, 32'hDEADBEEF);

    // starvation forces the secondary through
    stall_at = -1;
    for (int c = 0; c < 8; c++) begin
      drive(1, 2, c, c == 0, 7, 32'h11, 7, 0);
      step();
      if (last_stall && stall_at < 0) stall_at = c;
    end
    chk("t3_stall_cycle", stall_at, 32'd5);

    // back-pressure with three secondary pushes
    idle(3);
    for (int c = 0; c < 14; c++) begin
      drive(1, 6, c, c < 3 || s_valid && !s_ready,
            1 + (c < 3 ? c : 2), c, 2, 3);
      step();
    end

    // pending lookup on reg 9, and reg 0 never pending
    idle(3);
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, c, c == 0, 9, 32'h99, 9, 0);
      step();
    end
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, c, c == 0, 0, 32'h5, 0, 0);
      step();
    end

    // $zero primary write is consumed silently
    drive(1, 0, 32'h1234, 0, 0, 0, 0, 0);
    step();
    chk("t6_zero_wen", 32'(W_Enable), 32'd0);

    // idle secondary latency
    idle(4);
    drive(0, 0, 0, 1, 4, 32'h44, 0, 0);
    step();
    lat = 1;
    while (!W_Enable && lat < 6) begin
      idle(1);
      lat++;
    end
    chk("t6_latency", lat, BYP ? 32'd1 : 32'd2);
    chk("t6_wreg", 32'(W_Reg), 32'd4);

    rand_phase(400, 60, 40);
    rand_phase(300, 95, 50);
    rand_phase(200, 20, 70);

    // async reset while a write is in the output reg
    drive(1, 3, 32'hABCD, 1, 2, 32'h22, 0, 0);
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_wen", 32'(W_Enable), 32'd0);
    chk("arst_cnt", 32'(fifo_cnt), 32'd0);
    do_reset();
    rand_phase(200, 70, 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
